// File: rtl/nn_layer_sequencer.sv
// Sequencer for one fully-connected layer: walks neurons and inputs, drives ROM/buffer addresses and MAC controls.
// Optional NN_SEQ_PERF_CNT_EN adds a saturating layer_cycles busy-cycle counter.
module nn_layer_sequencer #(
    parameter int unsigned NUM_INPUTS  = 784,
    parameter int unsigned NUM_NEURONS = 10,
    parameter int unsigned ROM_LAT     = 1,
    parameter int unsigned CNT_W       = 10,
    parameter int unsigned NEUR_W      = 4,
    parameter int unsigned ADDR_W      = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inp_rdy,
    output logic [CNT_W-1:0]  inp_count,
    output logic [CNT_W-1:0]  inp_count_d,
    output logic [ADDR_W-1:0] weight_addr,
    output logic              acc_clr,
    output logic              mac_en,
    output logic              bias_en,
    output logic              out_wr,
    output logic [NEUR_W-1:0] neuron_idx,
    output logic              busy,
    output logic              done
`ifdef NN_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       layer_cycles
`endif
);

    localparam int unsigned DRN_W  = 3;
    localparam int unsigned PIPE_W = ROM_LAT * CNT_W;
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(NUM_INPUTS - 1);
    localparam logic [NEUR_W-1:0] LAST_NEUR = NEUR_W'(NUM_NEURONS - 1);
    localparam logic [DRN_W-1:0]  LAST_DRN  = DRN_W'(ROM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_BIAS, S_WRITE, S_DONE
    } state_e;

    state_e state_q, state_d;

    logic                           inp_rdy_q, inp_rdy_d;
    logic [CNT_W-1:0]               idx_q, idx_d;
    logic [NEUR_W-1:0]              neur_q, neur_d;
    logic [DRN_W-1:0]               drn_q, drn_d;
    logic [ROM_LAT-1:0]             vld_pipe_q, vld_pipe_d;
    logic [ROM_LAT-1:0][CNT_W-1:0]  cnt_pipe_q, cnt_pipe_d;
    logic                           rdy_rise;
    logic                           start;
    logic                           addr_valid;

    assign rdy_rise = inp_rdy & ~inp_rdy_q;
    assign start    = rdy_rise & (state_q == S_IDLE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: state_d = S_ACCUM;
            S_ACCUM: if (idx_q == LAST_IDX) state_d = S_DRAIN;
            S_DRAIN: if (drn_q == LAST_DRN) state_d = S_BIAS;
            S_BIAS:  state_d = S_WRITE;
            S_WRITE: state_d = (neur_q == LAST_NEUR) ? S_DONE : S_CLEAR;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        addr_valid = 1'b0;
        acc_clr    = 1'b0;
        bias_en    = 1'b0;
        out_wr     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_CLEAR: begin acc_clr = 1'b1; busy = 1'b1; end
            S_ACCUM: begin addr_valid = 1'b1; busy = 1'b1; end
            S_DRAIN: busy = 1'b1;
            S_BIAS:  begin bias_en = 1'b1; busy = 1'b1; end
            S_WRITE: begin out_wr = 1'b1; busy = 1'b1; end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Index counters and latency-alignment pipelines
    always_comb begin
        inp_rdy_d  = inp_rdy;
        idx_d      = idx_q;
        neur_d     = neur_q;
        drn_d      = drn_q;
        vld_pipe_d = ROM_LAT'({vld_pipe_q, addr_valid});
        cnt_pipe_d = PIPE_W'({cnt_pipe_q, idx_q});
        case (state_q)
            S_IDLE:  if (start) neur_d = '0;
            S_CLEAR: idx_d = '0;
            S_ACCUM: begin
                drn_d = '0;
                if (idx_q != LAST_IDX) idx_d = idx_q + CNT_W'(1);
            end
            S_DRAIN: drn_d = drn_q + DRN_W'(1);
            S_WRITE: if (neur_q != LAST_NEUR) neur_d = neur_q + NEUR_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inp_rdy_q  <= 1'b0;
            idx_q      <= '0;
            neur_q     <= '0;
            drn_q      <= '0;
            vld_pipe_q <= '0;
            cnt_pipe_q <= '0;
        end else begin
            inp_rdy_q  <= inp_rdy_d;
            idx_q      <= idx_d;
            neur_q     <= neur_d;
            drn_q      <= drn_d;
            vld_pipe_q <= vld_pipe_d;
            cnt_pipe_q <= cnt_pipe_d;
        end
    end

    assign inp_count   = idx_q;
    assign inp_count_d = cnt_pipe_q[ROM_LAT-1];
    assign mac_en      = vld_pipe_q[ROM_LAT-1];
    assign neuron_idx  = neur_q;
    assign weight_addr = ADDR_W'(neur_q) * ADDR_W'(NUM_INPUTS) + ADDR_W'(idx_q);

`ifdef NN_SEQ_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    // Busy-cycle counter: restarts on an accepted start, saturates, holds between passes
    always_comb begin
        perf_d = perf_q;
        if (start) begin
            perf_d = '0;
        end else if (busy && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign layer_cycles = perf_q;
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Randomized bench for nn_layer_sequencer: two configurations checked every cycle against a
// position-in-pass reference model (pass position -> expected controls via plain arithmetic).
module tb_nn_layer_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic inp_rdy;

    always #5 clk = ~clk;

    // Config A: 4 inputs, 2 neurons, latency 1
    logic [9:0]  a_inp_count, a_inp_count_d;
    logic [12:0] a_weight_addr;
    logic [3:0]  a_neuron_idx;
    logic        a_acc_clr, a_mac_en, a_bias_en, a_out_wr, a_busy, a_done;
    // Config B: 5 inputs, 3 neurons, latency 3
    logic [9:0]  b_inp_count, b_inp_count_d;
    logic [12:0] b_weight_addr;
    logic [3:0]  b_neuron_idx;
    logic        b_acc_clr, b_mac_en, b_bias_en, b_out_wr, b_busy, b_done;
`ifdef NN_SEQ_PERF_CNT_EN
    logic [31:0] a_layer_cycles, b_layer_cycles;
`endif

    nn_layer_sequencer #(
        .NUM_INPUTS(4), .NUM_NEURONS(2), .ROM_LAT(1), .CNT_W(10), .NEUR_W(4), .ADDR_W(13)
    ) dut_a (
        .clk(clk), .reset(reset), .inp_rdy(inp_rdy),
        .inp_count(a_inp_count), .inp_count_d(a_inp_count_d), .weight_addr(a_weight_addr),
        .acc_clr(a_acc_clr), .mac_en(a_mac_en), .bias_en(a_bias_en), .out_wr(a_out_wr),
        .neuron_idx(a_neuron_idx), .busy(a_busy), .done(a_done)
`ifdef NN_SEQ_PERF_CNT_EN
        , .layer_cycles(a_layer_cycles)
`endif
    );

    nn_layer_sequencer #(
        .NUM_INPUTS(5), .NUM_NEURONS(3), .ROM_LAT(3), .CNT_W(10), .NEUR_W(4), .ADDR_W(13)
    ) dut_b (
        .clk(clk), .reset(reset), .inp_rdy(inp_rdy),
        .inp_count(b_inp_count), .inp_count_d(b_inp_count_d), .weight_addr(b_weight_addr),
        .acc_clr(b_acc_clr), .mac_en(b_mac_en), .bias_en(b_bias_en), .out_wr(b_out_wr),
        .neuron_idx(b_neuron_idx), .busy(b_busy), .done(b_done)
`ifdef NN_SEQ_PERF_CNT_EN
        , .layer_cycles(b_layer_cycles)
`endif
    );

    // pos = -1 when idle, otherwise cycles since the pass's first CLEAR cycle (pos == m*P is DONE)
    typedef struct {
        int n; int m; int l;
        int pos; int prev; int inp; int neur;
        int hv[4]; int hc[4];
    } mdl_t;

    mdl_t ma, mb;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   done_a, done_b, first_a, first_b, c0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic mdl_t mdl_clear(input mdl_t s);
        s.pos = -1; s.prev = 0; s.inp = 0; s.neur = 0;
        for (int i = 0; i < 4; i++) begin
            s.hv[i] = 0; s.hc[i] = 0;
        end
        return s;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t s, input logic rdy);
        int  per, tot, r;
        bit  bsy, av, rise;
        per = s.n + s.l + 3;
        tot = s.m * per;
        bsy = (s.pos >= 0) && (s.pos < tot);
        r   = bsy ? (s.pos % per) : -1;
        av  = bsy && (r >= 1) && (r <= s.n);
        for (int i = 3; i > 0; i--) begin
            s.hv[i] = s.hv[i-1]; s.hc[i] = s.hc[i-1];
        end
        s.hv[0] = av ? 1 : 0;
        s.hc[0] = s.inp;
        rise   = rdy && (s.prev == 0);
        s.prev = rdy ? 1 : 0;
        if (s.pos < 0) begin
            if (rise) s.pos = 0;
        end else if (s.pos == tot) begin
            s.pos = -1;
        end else begin
            s.pos++;
        end
        if ((s.pos >= 0) && (s.pos < tot)) begin
            r      = s.pos % per;
            s.neur = s.pos / per;
            if ((r >= 1) && (r <= s.n)) s.inp = r - 1;
            else if (r > s.n)           s.inp = s.n - 1;
        end
        return s;
    endfunction

    task automatic check_dut(input string pfx, input mdl_t s, input logic [5:0] ctl,
                             input logic [31:0] ic, input logic [31:0] icd,
                             input logic [31:0] nr, input logic [31:0] wa);
        int per, tot, r;
        bit bsy;
        logic [5:0] exp_ctl;
        per = s.n + s.l + 3;
        tot = s.m * per;
        bsy = (s.pos >= 0) && (s.pos < tot);
        r   = bsy ? (s.pos % per) : -1;
        exp_ctl = {bsy && (r == 0), s.hv[s.l-1] != 0, r == s.n + s.l + 1,
                   r == s.n + s.l + 2, bsy, s.pos == tot};
        check_eq({pfx, ".ctl"},   32'(ctl), 32'(exp_ctl));
        check_eq({pfx, ".inp"},   ic,  32'(s.inp));
        check_eq({pfx, ".inp_d"}, icd, 32'(s.hc[s.l-1]));
        check_eq({pfx, ".neur"},  nr,  32'(s.neur));
        check_eq({pfx, ".waddr"}, wa,  32'(s.neur * s.n + s.inp));
    endtask

    task automatic check_all();
        check_dut("a", ma, {a_acc_clr, a_mac_en, a_bias_en, a_out_wr, a_busy, a_done},
                  32'(a_inp_count), 32'(a_inp_count_d), 32'(a_neuron_idx), 32'(a_weight_addr));
        check_dut("b", mb, {b_acc_clr, b_mac_en, b_bias_en, b_out_wr, b_busy, b_done},
                  32'(b_inp_count), 32'(b_inp_count_d), 32'(b_neuron_idx), 32'(b_weight_addr));
        if (a_done === 1'b1) begin
            done_a++;
            if (first_a < 0) first_a = cyc;
        end
        if (b_done === 1'b1) begin
            done_b++;
            if (first_b < 0) first_b = cyc;
        end
    endtask

    // One clock: advance models on the rising edge, compare on the falling edge
    task automatic cycle();
        @(posedge clk);
        if (reset) begin
            ma = mdl_clear(ma); mb = mdl_clear(mb);
        end else begin
            ma = mdl_step(ma, inp_rdy); mb = mdl_step(mb, inp_rdy);
        end
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        ma = mdl_clear(ma); mb = mdl_clear(mb);
        check_all();
    endtask

    initial begin
        ma.n = 4; ma.m = 2; ma.l = 1;
        mb.n = 5; mb.m = 3; mb.l = 3;
        ma = mdl_clear(ma); mb = mdl_clear(mb);
        done_a = 0; done_b = 0; first_a = -1; first_b = -1;
        reset = 1'b1; inp_rdy = 1'b0;
        #1;
        check_all();
        repeat (3) cycle();
        reset = 1'b0;
        repeat (3) cycle();

        // Held inp_rdy: one pass, one done, fixed edge-to-done latency
        done_a = 0; done_b = 0; first_a = -1; first_b = -1;
        c0 = cyc;
        inp_rdy = 1'b1;
        repeat (200) cycle();
        check_eq("hold.done_cnt_a", 32'(done_a), 32'd1);
        check_eq("hold.done_cnt_b", 32'(done_b), 32'd1);
        check_eq("hold.latency_a", 32'(first_a - c0), 32'(2 * (4 + 1 + 3) + 1));
        check_eq("hold.latency_b", 32'(first_b - c0), 32'(3 * (5 + 3 + 3) + 1));
        inp_rdy = 1'b0;
        repeat (5) cycle();

        // Extra rising edges mid-pass are dropped; a rise after done starts anew
        done_a = 0; done_b = 0;
        inp_rdy = 1'b1; cycle();
        inp_rdy = 1'b0; repeat (3) cycle();
        inp_rdy = 1'b1; cycle();
        inp_rdy = 1'b0; repeat (50) cycle();
        inp_rdy = 1'b1; repeat (50) cycle();
        inp_rdy = 1'b0; cycle();
        check_eq("reedge.done_cnt_a", 32'(done_a), 32'd2);
        check_eq("reedge.done_cnt_b", 32'(done_b), 32'd2);

        // Reset mid-pass: first in DRAIN of neuron 1 of config A, then random offsets
        for (int k = 0; k < 6; k++) begin
            done_a = 0;
            inp_rdy = 1'b1;
            repeat ((k == 0) ? 14 : $urandom_range(1, 40)) cycle();
            async_reset();
            repeat (2) cycle();
            if (k == 0) check_eq("rst.no_done_a", 32'(done_a), 32'd0);
            inp_rdy = 1'($urandom_range(0, 1));
            reset = 1'b0;
            repeat (45) cycle();
            inp_rdy = 1'b0;
            cycle();
        end

        // Random inp_rdy toggling with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) inp_rdy = ~inp_rdy;
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
                cycle();
                reset = 1'b0;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
